// File: rtl/bp_lce_req_concentrator.sv
// ---------------------------------------------------------------------------
// bp_lce_req_concentrator
//
// Merges num_lce_p LCE request channels onto one output register. The block
// picks channels round-robin and tracks per-channel credits for outstanding
// requests.
//
// Optional feature (compile-time macro): BP_LCE_CONC_SRC_TAG_EN
//   defined   : lce_req_o = {granted channel index, packet}
//   undefined : lce_req_o = packet only
//
// Ports
//   clk_i            single clock
//   reset_n_i        asynchronous active-low reset
//   lce_req_i        per-channel packets, channel n at [n*W +: W]
//   lce_req_v_i      per-channel valid
//   lce_req_ready_o  per-channel ready (asserted only for the granted channel)
//   lce_req_o        merged request (registered)
//   lce_req_v_o      merged valid (registered)
//   lce_req_ready_i  downstream ready
//   req_complete_i   per-channel completion pulse, returns one credit
//   credits_full_o   channel counter == credits_p
//   credits_empty_o  channel counter == 0
//   underflow_o      sticky: completion seen while the counter was 0
// ---------------------------------------------------------------------------
module bp_lce_req_concentrator #(
    parameter int num_lce_p       = 2,
    parameter int lce_req_width_p = 128,
    parameter int credits_p       = 8,
    localparam int tag_w_lp = $clog2(num_lce_p),
    localparam int cnt_w_lp = $clog2(credits_p + 1),
`ifdef BP_LCE_CONC_SRC_TAG_EN
    localparam int out_w_lp = lce_req_width_p + tag_w_lp
`else
    localparam int out_w_lp = lce_req_width_p
`endif
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic [num_lce_p*lce_req_width_p-1:0] lce_req_i,
    input  logic [num_lce_p-1:0]                 lce_req_v_i,
    output logic [num_lce_p-1:0]                 lce_req_ready_o,
    output logic [out_w_lp-1:0]                  lce_req_o,
    output logic                                 lce_req_v_o,
    input  logic                                 lce_req_ready_i,
    input  logic [num_lce_p-1:0]                 req_complete_i,
    output logic [num_lce_p-1:0]                 credits_full_o,
    output logic [num_lce_p-1:0]                 credits_empty_o,
    output logic [num_lce_p-1:0]                 underflow_o
);

    logic                 v_q, v_d;
    logic [out_w_lp-1:0]  data_q, data_d;
    logic [tag_w_lp-1:0]  rr_q, rr_d;          // first channel to search
    logic [cnt_w_lp-1:0]  cnt_q [num_lce_p];
    logic [cnt_w_lp-1:0]  cnt_d [num_lce_p];
    logic [num_lce_p-1:0] uf_q, uf_d;

    logic                       loadable;
    logic [num_lce_p-1:0]       eligible;
    logic                       grant_found;
    logic [tag_w_lp-1:0]        grant_idx;
    logic                       do_grant;
    logic [num_lce_p-1:0]       grant_vec;
    logic [lce_req_width_p-1:0] grant_pkt;
    int                         idx;

    always_comb begin
        for (int n = 0; n < num_lce_p; n++) begin
            credits_full_o[n]  = (cnt_q[n] == cnt_w_lp'(credits_p));
            credits_empty_o[n] = (cnt_q[n] == '0);
        end
    end

    // Eligibility uses the registered counter, so a completion arriving in the
    // same cycle as a full counter does not open the channel until next cycle.
    assign eligible = lce_req_v_i & ~credits_full_o;
    assign loadable = !v_q || lce_req_ready_i;

    // Round-robin search starting at rr_q, wrapping modulo num_lce_p.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int i = 0; i < num_lce_p; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= num_lce_p) idx = idx - num_lce_p;
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant_idx   = tag_w_lp'(idx);
            end
        end
    end

    // Ready is gated by reset so no channel is handshaken while reset is held.
    assign do_grant  = loadable && grant_found && reset_n_i;
    assign grant_pkt = lce_req_i[int'(grant_idx)*lce_req_width_p +: lce_req_width_p];

    always_comb begin
        for (int n = 0; n < num_lce_p; n++) begin
            grant_vec[n] = do_grant && (grant_idx == tag_w_lp'(n));
        end
    end
    assign lce_req_ready_o = grant_vec;

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        rr_d   = rr_q;
        if (loadable) begin
            v_d = do_grant;
            if (do_grant) begin
`ifdef BP_LCE_CONC_SRC_TAG_EN
                data_d = {grant_idx, grant_pkt};
`else
                data_d = grant_pkt;
`endif
                rr_d = (int'(grant_idx) == num_lce_p - 1) ? '0
                                                          : grant_idx + tag_w_lp'(1);
            end
        end
    end

    // Credit counters: a grant and a completion in the same cycle cancel out;
    // a lone completion at zero holds the counter and flags underflow.
    always_comb begin
        uf_d = uf_q;
        for (int n = 0; n < num_lce_p; n++) begin
            cnt_d[n] = cnt_q[n];
            unique case ({grant_vec[n], req_complete_i[n]})
                2'b10: cnt_d[n] = cnt_q[n] + cnt_w_lp'(1);
                2'b01: begin
                    if (cnt_q[n] == '0) uf_d[n] = 1'b1;
                    else                cnt_d[n] = cnt_q[n] - cnt_w_lp'(1);
                end
                default: cnt_d[n] = cnt_q[n];
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_q    <= 1'b0;
            data_q <= '0;
            rr_q   <= '0;
            uf_q   <= '0;
            for (int n = 0; n < num_lce_p; n++) cnt_q[n] <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
            rr_q   <= rr_d;
            uf_q   <= uf_d;
            for (int n = 0; n < num_lce_p; n++) cnt_q[n] <= cnt_d[n];
        end
    end

    assign lce_req_v_o = v_q;
    assign lce_req_o   = data_q;
    assign underflow_o = uf_q;

endmodule

// File: tb/tb_bp_lce_req_concentrator.sv
// ---------------------------------------------------------------------------
// Testbench for bp_lce_req_concentrator: 4 channels, 2 credits, 16-bit
// packets. A behavioural model tracks credits, sticky underflow, the last
// granted channel and the output register; a compare process checks every
// DUT output against it on each falling edge. Directed phases add literal
// expectations for fairness, credit blocking, back-pressure, underflow and
// reset. Honours BP_LCE_CONC_SRC_TAG_EN.
// ---------------------------------------------------------------------------
module tb_bp_lce_req_concentrator;
    localparam int N    = 4;
    localparam int W    = 16;
    localparam int CRED = 2;
`ifdef BP_LCE_CONC_SRC_TAG_EN
    localparam int OW = W + 2;
`else
    localparam int OW = W;
`endif

    logic            clk = 1'b0;
    logic            reset_n_i;
    logic [N*W-1:0]  lce_req_i;
    logic [N-1:0]    lce_req_v_i;
    logic [N-1:0]    lce_req_ready_o;
    logic [OW-1:0]   lce_req_o;
    logic            lce_req_v_o;
    logic            lce_req_ready_i;
    logic [N-1:0]    req_complete_i;
    logic [N-1:0]    credits_full_o;
    logic [N-1:0]    credits_empty_o;
    logic [N-1:0]    underflow_o;

    bp_lce_req_concentrator #(
        .num_lce_p(N), .lce_req_width_p(W), .credits_p(CRED)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .lce_req_i(lce_req_i), .lce_req_v_i(lce_req_v_i),
        .lce_req_ready_o(lce_req_ready_o),
        .lce_req_o(lce_req_o), .lce_req_v_o(lce_req_v_o),
        .lce_req_ready_i(lce_req_ready_i),
        .req_complete_i(req_complete_i),
        .credits_full_o(credits_full_o), .credits_empty_o(credits_empty_o),
        .underflow_o(underflow_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ model
    int           m_cnt [N];
    bit [N-1:0]   m_uf;
    int           m_last;        // last granted channel; N-1 => search begins at 0
    bit           m_v;
    logic [OW-1:0] m_data;

    function automatic logic [OW-1:0] mk(input int ch, input logic [W-1:0] pkt);
`ifdef BP_LCE_CONC_SRC_TAG_EN
        return {2'(ch), pkt};
`else
        return pkt;
`endif
    endfunction

    function automatic int m_pick();
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (lce_req_v_i[c] && m_cnt[c] < CRED) return c;
        end
        return -1;
    endfunction

    task automatic m_reset();
        for (int n = 0; n < N; n++) m_cnt[n] = 0;
        m_uf = '0; m_last = N - 1; m_v = 0; m_data = '0;
    endtask

    // Compare process: inputs change just after the rising edge, so on the
    // falling edge both registered outputs and ready are settled.
    always @(negedge clk) begin
        int g;
        bit ld;
        logic [N-1:0] exp_rdy, exp_full, exp_empty;
        if (!reset_n_i) m_reset();
        ld = !m_v || lce_req_ready_i;
        g  = m_pick();
        exp_rdy = '0;
        if (reset_n_i && ld && g >= 0) exp_rdy[g] = 1'b1;
        for (int n = 0; n < N; n++) begin
            exp_full[n]  = (m_cnt[n] == CRED);
            exp_empty[n] = (m_cnt[n] == 0);
        end
        chk("m_valid", 64'(lce_req_v_o), 64'(m_v));
        if (m_v) chk("m_data", 64'(lce_req_o), 64'(m_data));
        chk("m_ready", 64'(lce_req_ready_o), 64'(exp_rdy));
        chk("m_full",  64'(credits_full_o),  64'(exp_full));
        chk("m_empty", 64'(credits_empty_o), 64'(exp_empty));
        chk("m_uflow", 64'(underflow_o),     64'(m_uf));
        if (reset_n_i) begin
            for (int n = 0; n < N; n++) begin
                bit inc, dec;
                inc = ld && (g == n);
                dec = req_complete_i[n];
                if (inc && !dec) m_cnt[n]++;
                else if (dec && !inc) begin
                    if (m_cnt[n] == 0) m_uf[n] = 1'b1;
                    else m_cnt[n]--;
                end
            end
            if (ld) begin
                m_v = (g >= 0);
                if (g >= 0) begin
                    m_data = mk(g, lce_req_i[g*W +: W]);
                    m_last = g;
                end
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] fpkt(input int ch);
        return 16'hA000 + 16'(ch * 16'h111);
    endfunction

    initial begin
        reset_n_i = 1'b0; lce_req_i = '0; lce_req_v_i = '0;
        lce_req_ready_i = 1'b0; req_complete_i = '0;
        repeat (2) tick();

        // Reset state, with every channel requesting.
        lce_req_v_i = '1; lce_req_ready_i = 1'b1;
        for (int c = 0; c < N; c++) lce_req_i[c*W +: W] = fpkt(c);
        #1;
        chk("rst_valid", 64'(lce_req_v_o), 64'd0);
        chk("rst_ready", 64'(lce_req_ready_o), 64'd0);
        chk("rst_empty", 64'(credits_empty_o), 64'hF);
        chk("rst_full",  64'(credits_full_o), 64'd0);
        chk("rst_uflow", 64'(underflow_o), 64'd0);
        tick();

        // Fairness: release, all valid, downstream always ready.
        reset_n_i = 1'b1;
        for (int k = 0; k < 2 * N; k++) begin
            tick();
            chk("fair_valid", 64'(lce_req_v_o), 64'd1);
            chk("fair_data", 64'(lce_req_o), 64'(mk(k % N, fpkt(k % N))));
        end
        chk("fair_full", 64'(credits_full_o), 64'hF);
        lce_req_v_i = '0;
        tick();
        chk("fair_drain", 64'(lce_req_v_o), 64'd0);

        // Return all credits.
        req_complete_i = '1;
        tick(); tick();
        req_complete_i = '0;
        chk("drain_empty", 64'(credits_empty_o), 64'hF);

        // Credit blocking on channel 0.
        lce_req_v_i = 4'b0001;
        tick(); tick();
        #1;
        chk("cb_full", 64'(credits_full_o[0]), 64'd1);
        chk("cb_rdy_blocked", 64'(lce_req_ready_o[0]), 64'd0);
        tick();
        req_complete_i = 4'b0001;               // completion while full
        #1;
        chk("cb_rdy_same_cycle", 64'(lce_req_ready_o[0]), 64'd0);
        tick();
        req_complete_i = '0;
        #1;
        chk("cb_rdy_after", 64'(lce_req_ready_o[0]), 64'd1);
        tick();
        chk("cb_refull", 64'(credits_full_o[0]), 64'd1);
        lce_req_v_i = '0; req_complete_i = 4'b0001;
        tick();                                 // counter 1
        lce_req_v_i = 4'b0001;                  // grant + completion at 1
        #1;
        chk("gc_rdy", 64'(lce_req_ready_o[0]), 64'd1);
        tick();
        lce_req_v_i = '0; req_complete_i = '0;
        chk("gc_not_full",  64'(credits_full_o[0]), 64'd0);
        chk("gc_not_empty", 64'(credits_empty_o[0]), 64'd0);
        req_complete_i = 4'b0001;
        tick();
        req_complete_i = '0;
        tick();

        // Back-pressure on channel 1.
        lce_req_ready_i = 1'b0; lce_req_v_i = 4'b0010;
        lce_req_i[W +: W] = 16'h1234;
        tick();
        lce_req_i[W +: W] = 16'h5678;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_data", 64'(lce_req_o), 64'(mk(1, 16'h1234)));
            chk("bp_valid", 64'(lce_req_v_o), 64'd1);
            chk("bp_ready", 64'(lce_req_ready_o), 64'd0);
        end
        lce_req_ready_i = 1'b1;
        tick();
        chk("bp_next", 64'(lce_req_o), 64'(mk(1, 16'h5678)));
        lce_req_v_i = '0;
        tick();

        // Underflow on channel 1 (two credits outstanding, three completions).
        req_complete_i = 4'b0010;
        tick(); tick(); tick();
        req_complete_i = '0;
        tick();
        chk("uf_flag", 64'(underflow_o), 64'b0010);
        chk("uf_empty", 64'(credits_empty_o[1]), 64'd1);

        // Reset in the middle of a held transfer.
        lce_req_ready_i = 1'b0; lce_req_v_i = 4'b0100;
        tick();
        chk("rm_held", 64'(lce_req_v_o), 64'd1);
        reset_n_i = 1'b0;
        #1;
        chk("rm_valid", 64'(lce_req_v_o), 64'd0);
        chk("rm_empty", 64'(credits_empty_o), 64'hF);
        chk("rm_uflow", 64'(underflow_o), 64'd0);
        tick();
        reset_n_i = 1'b1;
        lce_req_ready_i = 1'b1; lce_req_v_i = '0;
        tick();

        // Random traffic, with occasional reset pulses.
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < N; c++) lce_req_i[c*W +: W] = 16'($urandom);
            lce_req_v_i     = 4'($urandom);
            lce_req_ready_i = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < N; c++) req_complete_i[c] = ($urandom_range(0, 4) == 0);
            reset_n_i = ($urandom_range(0, 199) != 0);
            tick();
        end
        reset_n_i = 1'b1; lce_req_v_i = '0; req_complete_i = '0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
